// File: rtl/result_uart_streamer_pkg.sv
// Shared definitions for the result UART streamer.
// Holds the UART framing constants (8N1-style: one start bit, one stop bit, no parity),
// the streamer FSM state encoding and the bit-level serializer phase encoding.
package result_uart_streamer_pkg;

  localparam int unsigned StartBits  = 1;
  localparam int unsigned StopBits   = 1;
  localparam int unsigned ParityBits = 0;

  // RAM sequencing states; StStart/StData/StStop track the frame the serializer is sending.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StStart,
    StData,
    StStop,
    StNext,
    StDone
  } stream_state_e;

  typedef enum logic [1:0] {
    SerIdle,
    SerStart,
    SerData,
    SerStop
  } ser_phase_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Bit-level UART transmitter: one start bit, DataBits data bits LSB first, one stop bit.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - synchronous active-low reset; forces the line high and the phase idle
//   load_i     - accept data_i and begin a frame (honoured only while ready_o is high)
//   data_i     - word to send
//   ready_o    - serializer idle, a load will be accepted
//   bit_end_o  - last clock of the current bit period (start, data or stop)
//   last_bit_o - the bit index points at the final data bit
//   tx_o       - registered serial line, idle high
module uart_tx_serializer
  import result_uart_streamer_pkg::*;
#(
  parameter int unsigned DataBits   = 8,
  parameter int unsigned ClksPerBit = 434
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [DataBits-1:0] data_i,
  output logic                ready_o,
  output logic                bit_end_o,
  output logic                last_bit_o,
  output logic                tx_o
);

  localparam int unsigned BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned IdxW  = (DataBits > 1) ? $clog2(DataBits) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DataBits - 1);

  ser_phase_e          phase_q, phase_d;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                bit_end;

  always_comb begin
    phase_d = phase_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    bit_end = (phase_q != SerIdle) && (baud_q == BaudLast);

    if (phase_q != SerIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (phase_q)
      SerIdle: begin
        if (load_i) begin
          shift_d = data_i;
          tx_d    = 1'b0;
          baud_d  = '0;
          idx_d   = '0;
          phase_d = SerStart;
        end
      end
      SerStart: begin
        if (bit_end) begin
          // Present bit 0 and pre-shift so shift_q[0] is always the next bit to send.
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          phase_d = SerData;
        end
      end
      SerData: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            tx_d    = 1'b1;
            phase_d = SerStop;
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      SerStop: begin
        if (bit_end) begin
          phase_d = SerIdle;
        end
      end
      default: phase_d = SerIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q <= SerIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign ready_o    = (phase_q == SerIdle);
  assign bit_end_o  = bit_end;
  assign last_bit_o = (idx_q == IdxLast);
  assign tx_o       = tx_q;

endmodule

// File: rtl/result_uart_streamer.sv
// Streams the result RAM (addresses 0..NUM_SAMPLES-1) once over a UART line per start request.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset; aborts any frame in flight
//   start      - begin one run; ignored while busy or during the done cycle
//   ram_rdaddr - result RAM read address (holds its last value after a run)
//   ram_q      - result RAM data, valid one clock after ram_rdaddr changes
//   tx         - registered UART line, idle high
//   busy       - high from start acceptance through the final stop bit
//   done       - one-cycle pulse after the last stop bit
module result_uart_streamer
  import result_uart_streamer_pkg::*;
#(
  parameter int unsigned data_bits    = 8,
  parameter int unsigned addr_bits    = 8,
  parameter int unsigned NUM_SAMPLES  = 255,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [addr_bits-1:0] ram_rdaddr,
  input  logic [data_bits-1:0] ram_q,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [addr_bits-1:0] LastAddr = addr_bits'(NUM_SAMPLES - 1);

  stream_state_e        state_q, state_d;
  logic [addr_bits-1:0] addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic ser_load;
  logic ser_ready;
  logic ser_bit_end;
  logic ser_last_bit;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ser_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = StFetch;
        end
      end
      // FETCH lets the new address reach the RAM; ram_q is valid by the end of WAIT.
      StFetch: state_d = StWait;
      StWait: begin
        ser_load = ser_ready;
        if (ser_ready) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (ser_bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (ser_bit_end && ser_last_bit) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (ser_bit_end) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (addr_q == LastAddr) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_serializer #(
    .DataBits  (data_bits),
    .ClksPerBit(CLKS_PER_BIT)
  ) u_serializer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (ser_load),
    .data_i    (ram_q),
    .ready_o   (ser_ready),
    .bit_end_o (ser_bit_end),
    .last_bit_o(ser_last_bit),
    .tx_o      (tx)
  );

  assign ram_rdaddr = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_result_uart_streamer.sv
// Bench for result_uart_streamer with CLKS_PER_BIT=4, NUM_SAMPLES=3.
// A negedge UART monitor decodes frames into rx_q; each test pushes the bytes it expects
// into exp_q when it issues start and compares the two queues once the run ends.
module tb_result_uart_streamer;

  localparam int CPB      = 4;
  localparam int NS       = 3;
  localparam int FrameCyc = 10 * CPB;
  localparam int Gap      = 3;

  typedef struct {
    logic [7:0] data;
    int         start_cyc;
    bit         ok;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] ram_rdaddr;
  logic [7:0] ram_q;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:255];
  logic [7:0] exp_q[$];
  frame_t     rx_q[$];

  int checks = 0;
  int errors = 0;

  // Monitor state
  int     mon_cyc   = 0;
  int     busy_cyc  = 0;
  int     done_cnt  = 0;
  bit     in_frame  = 1'b0;
  int     nsmp      = 0;
  int     f_start   = 0;
  logic   smp [0:FrameCyc-1];
  frame_t mfr;

  result_uart_streamer #(
    .data_bits   (8),
    .addr_bits   (8),
    .NUM_SAMPLES (NS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram_rdaddr(ram_rdaddr),
    .ram_q     (ram_q),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model
  always @(posedge clk) ram_q <= mem[ram_rdaddr];

  always @(negedge clk) begin
    mon_cyc++;
    if (busy === 1'b1) busy_cyc++;
    if (done === 1'b1) done_cnt++;
    if (rst !== 1'b1) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        nsmp     = 1;
        smp[0]   = 1'b0;
        f_start  = mon_cyc;
      end
    end else begin
      smp[nsmp] = tx;
      nsmp++;
      if (nsmp == FrameCyc) begin
        mfr.ok = 1'b1;
        for (int k = 0; k < 10; k++)
          for (int j = 1; j < CPB; j++)
            if (smp[k*CPB+j] !== smp[k*CPB]) mfr.ok = 1'b0;
        if (smp[9*CPB] !== 1'b1) mfr.ok = 1'b0;
        for (int i = 0; i < 8; i++) mfr.data[i] = smp[(i+1)*CPB];
        mfr.start_cyc = f_start;
        rx_q.push_back(mfr);
        in_frame = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output bit to);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    to = (done !== 1'b1);
  endtask

  task automatic wait_frame(input int addr, input int limit, output bit to);
    int n = 0;
    while (!(tx === 1'b0 && int'(ram_rdaddr) == addr) && n < limit) begin
      step();
      n++;
    end
    to = !(tx === 1'b0 && int'(ram_rdaddr) == addr);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    rx_q.delete();
    busy_cyc = 0;
    done_cnt = 0;
  endtask

  task automatic push_run();
    for (int i = 0; i < NS; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) step();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++;
    if (ram_rdaddr !== 8'd0) begin
      errors++; $display("FAIL reset ram_rdaddr: got %0d want 0", ram_rdaddr);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_full_run();
    bit         to;
    frame_t     fr;
    logic [7:0] e;
    logic [9:0] pat;
    int         prev;
    int         idx;
    pat = 10'b1101001010;  // 0xA5 framed, index 0 = start bit
    clear_sb();
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run busy_after_start: got %b want 1", busy); end
    checks++;
    if (ram_rdaddr !== 8'd0) begin
      errors++; $display("FAIL run addr_after_start: got %0d want 0", ram_rdaddr);
    end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL run tx_fetch: got %b want 1", tx); end
    step();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL run tx_wait: got %b want 1", tx); end
    step();
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        checks++;
        if (tx !== pat[k]) begin
          errors++; $display("FAIL run a5_bit%0d_cyc%0d: got %b want %b", k, j, tx, pat[k]);
        end
        step();
      end
    end
    wait_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL run done_timeout: got no done want done"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run busy_in_done: got %b want 0", busy); end
    checks++;
    if (ram_rdaddr !== 8'(NS - 1)) begin
      errors++; $display("FAIL run addr_hold: got %0d want %0d", ram_rdaddr, NS - 1);
    end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL run done_width: got %b want 0", done); end
    step();
    checks++;
    if (busy_cyc != NS * FrameCyc + (NS - 1) * Gap + 3) begin
      errors++;
      $display("FAIL run busy_cycles: got %0d want %0d", busy_cyc, NS * FrameCyc + (NS - 1) * Gap + 3);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL run done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL run frame_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    idx = 0;
    prev = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      fr = rx_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (!fr.ok || fr.data !== e) begin
        errors++; $display("FAIL run frame%0d: got %02h ok=%0d want %02h ok=1", idx, fr.data, fr.ok, e);
      end
      if (idx > 0) begin
        checks++;
        if (fr.start_cyc - prev != FrameCyc + Gap) begin
          errors++;
          $display("FAIL run spacing%0d: got %0d want %0d", idx, fr.start_cyc - prev, FrameCyc + Gap);
        end
      end
      prev = fr.start_cyc;
      idx++;
    end
  endtask

  task automatic test_start_ignored();
    bit         to;
    frame_t     fr;
    logic [7:0] e;
    clear_sb();
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frame(1, 200, to);
    checks++; if (to) begin errors++; $display("FAIL ignore frame2_timeout: got none want frame"); end
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL ignore done_timeout: got no done want done"); end
    start = 1'b1;  // offered during the done cycle
    step();
    start = 1'b0;
    repeat (5) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore busy_after: got %b want 0", busy); end
    checks++;
    if (ram_rdaddr !== 8'(NS - 1)) begin
      errors++; $display("FAIL ignore addr_after: got %0d want %0d", ram_rdaddr, NS - 1);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ignore frame_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      fr = rx_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (!fr.ok || fr.data !== e) begin
        errors++; $display("FAIL ignore frame: got %02h ok=%0d want %02h ok=1", fr.data, fr.ok, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit         to;
    frame_t     fr;
    logic [7:0] e;
    for (int f = 0; f < 2; f++) begin
      clear_sb();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_frame(f, 200, to);
      checks++; if (to) begin errors++; $display("FAIL abort%0d frame_timeout: got none want frame", f); end
      repeat (CPB + 3 * CPB + 1) step();  // inside data bit 3
      rst = 1'b0;
      step();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort%0d tx: got %b want 1", f, tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort%0d busy: got %b want 0", f, busy); end
      checks++;
      if (ram_rdaddr !== 8'd0) begin
        errors++; $display("FAIL abort%0d addr: got %0d want 0", f, ram_rdaddr);
      end
      rst = 1'b1;
      repeat (2) step();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort%0d tx_idle: got %b want 1", f, tx); end
      clear_sb();
      push_run();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (ram_rdaddr !== 8'd0 || busy !== 1'b1) begin
        errors++; $display("FAIL abort%0d restart: got addr=%0d busy=%b want addr=0 busy=1", f, ram_rdaddr, busy);
      end
      wait_done(400, to);
      checks++; if (to) begin errors++; $display("FAIL abort%0d done_timeout: got no done want done", f); end
      step();
      checks++;
      if (rx_q.size() != exp_q.size()) begin
        errors++; $display("FAIL abort%0d frame_count: got %0d want %0d", f, rx_q.size(), exp_q.size());
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
        fr = rx_q.pop_front();
        e  = exp_q.pop_front();
        checks++;
        if (!fr.ok || fr.data !== e) begin
          errors++; $display("FAIL abort%0d frame: got %02h ok=%0d want %02h ok=1", f, fr.data, fr.ok, e);
        end
      end
    end
  endtask

  task automatic test_start_held();
    bit         to;
    frame_t     fr;
    logic [7:0] e;
    clear_sb();
    push_run();
    push_run();
    start = 1'b1;
    wait_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL held done1_timeout: got no done want done"); end
    step();  // IDLE
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL held idle: got busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
    step();  // FETCH
    checks++;
    if (busy !== 1'b1 || ram_rdaddr !== 8'd0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL held fetch: got busy=%b addr=%0d tx=%b want busy=1 addr=0 tx=1", busy, ram_rdaddr, tx);
    end
    step();  // WAIT
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL held wait_tx: got %b want 1", tx); end
    step();  // START
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL held start_bit: got %b want 0", tx); end
    start = 1'b0;
    wait_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL held done2_timeout: got no done want done"); end
    step();
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL held done_pulses: got %0d want 2", done_cnt); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL held frame_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      fr = rx_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (!fr.ok || fr.data !== e) begin
        errors++; $display("FAIL held frame: got %02h ok=%0d want %02h ok=1", fr.data, fr.ok, e);
      end
    end
  endtask

  task automatic test_extremes();
    bit         to;
    int         n;
    frame_t     fr;
    logic [7:0] e;
    mem[0] = 8'hFF;
    mem[1] = 8'h00;
    mem[2] = 8'h81;
    clear_sb();
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frame(0, 200, to);
    checks++; if (to) begin errors++; $display("FAIL ext frame_timeout: got none want frame"); end
    n = 0; while (tx === 1'b0 && n < 200) begin n++; step(); end
    checks++; if (n != CPB) begin errors++; $display("FAIL ext ff_low: got %0d want %0d", n, CPB); end
    n = 0; while (tx === 1'b1 && n < 200) begin n++; step(); end
    checks++;
    if (n != 9 * CPB + Gap) begin
      errors++; $display("FAIL ext ff_high: got %0d want %0d", n, 9 * CPB + Gap);
    end
    n = 0; while (tx === 1'b0 && n < 200) begin n++; step(); end
    checks++; if (n != 9 * CPB) begin errors++; $display("FAIL ext 00_low: got %0d want %0d", n, 9 * CPB); end
    n = 0; while (tx === 1'b1 && n < 200) begin n++; step(); end
    checks++; if (n != CPB + Gap) begin errors++; $display("FAIL ext 00_high: got %0d want %0d", n, CPB + Gap); end
    wait_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL ext done_timeout: got no done want done"); end
    step();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ext frame_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      fr = rx_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (!fr.ok || fr.data !== e) begin
        errors++; $display("FAIL ext frame: got %02h ok=%0d want %02h ok=1", fr.data, fr.ok, e);
      end
    end
    mem[0] = 8'hA5;
    mem[1] = 8'h00;
    mem[2] = 8'hFF;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hA5;
    mem[1] = 8'h00;
    mem[2] = 8'hFF;
    rst   = 1'b0;
    start = 1'b0;
    test_reset();
    test_full_run();
    test_start_ignored();
    test_reset_mid_frame();
    test_start_held();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
